lsu_wb_collector: RTL and testbench
===================================

// Module: lsu_wb_collector
// PURPOSE
//  Per-warp load-writeback collector, the producer side of the register file write port.
//  Accepts one outstanding load per warp: the issuing thread mask and destination rd.
//  Gathers per-thread LSU responses, which arrive out of order over many cycles.
//  Once every enabled thread has returned, presents one warp-wide writeback to the
//  register file: mask, rd and per-thread data (the lsu_out source).
// PARAMETERS
//  THREADS_PER_WARP  16           threads per warp; width of all masks
//  DATA_WIDTH        `DATA_WIDTH  bits per thread data word (data_t)
//  CNT_W             $clog2(THREADS_PER_WARP)+1  width of outstanding counter (derived)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-low reset
//  issue_valid    in   1          new load issued for this warp
//  issue_ready    out  1          collector idle, can accept issue
//  issue_mask     in   T          threads participating (thread_enable at issue)
//  issue_rd       in   5          destination register index
//  resp_valid     in   T          per-thread LSU response strobe
//  resp_data      in   data_t[T]  per-thread LSU response data
//  wb_valid       out  1          writeback ready for register file
//  wb_ready       in   1          register file consumes writeback (warp in WARP_UPDATE)
//  wb_mask        out  T          threads to write
//  wb_rd          out  5          destination register index
//  wb_data        out  data_t[T]  per-thread write data; 0 for masked-off threads
//  outstanding    out  CNT_W      count of pending threads
//  stray_resp     out  1          sticky: response seen for a non-pending thread
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - State goes to IDLE; pending mask cleared; data buffer cleared.
//   - wb_valid=0, wb_mask=0, wb_rd=0, wb_data=0, outstanding=0, stray_resp=0.
//   - issue_ready=1 from the first cycle after reset.
//  FSM with three states: IDLE, COLLECT, WRITEBACK.
//  IDLE:
//   - issue_ready=1.
//   - On issue_valid: latch issue_mask into pending and wb_mask, latch issue_rd into wb_rd.
//   - Same issue cycle: clear buffer words for threads with issue_mask[i]=0.
//   - outstanding <= popcount(issue_mask).
//   - Next state is COLLECT; if issue_mask==0, WRITEBACK directly with an empty mask,
//     so the warp never hangs.
//  COLLECT:
//   - issue_ready=0.
//   - Each cycle, every i with resp_valid[i] && pending[i]: buf[i] <= resp_data[i],
//     pending[i] <= 0.
//   - outstanding decrements by the number of such threads; multiple per cycle allowed.
//   - When pending is zero after this cycle's responses, go to WRITEBACK.
//   - wb_valid rises the cycle after the last response (1-cycle latency).
//  WRITEBACK:
//   - wb_valid=1 held, outputs stable, until wb_ready.
//   - On wb_valid && wb_ready, go to IDLE next cycle.
//   - At least one IDLE cycle between writeback and the next issue; no issue/wb overlap.
//  Stray responses:
//   - A stray is resp_valid[i] where pending[i]==0, or any resp_valid in IDLE or WRITEBACK.
//   - Strays are ignored for data; they set stray_resp, which is cleared only by reset.
//  rd handling:
//   - rd is passed unfiltered; the register file drops writes to rd 0 and rd 29..31.
//  Reset mid-operation:
//   - Aborts the load; no writeback is produced.
//   - Late responses from the aborted load count as strays.
//  issue_valid outside IDLE is ignored; the issuer must hold it until issue_ready.
// TESTING
//  1. Reset, then issue mask=FFFF rd=5; thread i returns data 100+i, in reverse order,
//     one per cycle. Expect wb_valid the cycle after the thread-0 response,
//     wb_data[i]=100+i, wb_mask=FFFF, wb_rd=5.
//  2. Issue mask=00A5; all 4 responses in one cycle. Expect outstanding 4->0,
//     wb_valid next cycle, wb_data=0 for unmasked threads.
//  3. Issue mask=0000. Expect wb_valid one cycle after issue, wb_mask=0.
//     Hold wb_ready=0 for 5 cycles: outputs stable, issue_ready=0.
//  4. In COLLECT with mask=0003: resp_valid=0004 and a duplicate on thread 0.
//     Expect stray_resp=1, data unchanged, outstanding unaffected by the strays.
//  5. Reset low mid-COLLECT: next cycle IDLE, wb_valid=0, outstanding=0.
//     A response arriving after reset sets stray_resp.
//  6. wb_ready asserted same cycle as new issue_valid: no issue accepted;
//     issue accepted on the following IDLE cycle.

Source files
------------

// File: rtl/lsu_wb_collector.sv
// Per-warp load writeback collector: gathers out-of-order per-thread LSU responses
// for one outstanding load and presents a single warp-wide register file writeback.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module lsu_wb_collector #(
    parameter int THREADS_PER_WARP = 16,
    parameter int DATA_WIDTH       = `DATA_WIDTH,
    parameter int CNT_W            = $clog2(THREADS_PER_WARP) + 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         issue_valid,
    output logic                                         issue_ready,
    input  logic [THREADS_PER_WARP-1:0]                  issue_mask,
    input  logic [4:0]                                   issue_rd,
    input  logic [THREADS_PER_WARP-1:0]                  resp_valid,
    input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]  resp_data,
    output logic                                         wb_valid,
    input  logic                                         wb_ready,
    output logic [THREADS_PER_WARP-1:0]                  wb_mask,
    output logic [4:0]                                   wb_rd,
    output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]  wb_data,
    output logic [CNT_W-1:0]                             outstanding,
    output logic                                         stray_resp
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITEBACK} state_t;

    state_t                                      state;
    state_t                                      state_next;
    logic [THREADS_PER_WARP-1:0]                 pending;
    logic [THREADS_PER_WARP-1:0]                 accept;
    logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] data_buf;
    logic [CNT_W-1:0]                            issue_count;
    logic [CNT_W-1:0]                            accept_count;
    logic                                        do_issue;
    logic                                        stray_now;

    function automatic logic [CNT_W-1:0] popcount(input logic [THREADS_PER_WARP-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < THREADS_PER_WARP; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Only responses for still-pending threads during COLLECT carry data; anything else is stray.
    assign accept       = (state == COLLECT) ? (resp_valid & pending) : '0;
    assign stray_now    = (state == COLLECT) ? |(resp_valid & ~pending) : |resp_valid;
    assign do_issue     = (state == IDLE) && issue_valid;
    assign issue_count  = popcount(issue_mask);
    assign accept_count = popcount(accept);
    assign wb_data      = data_buf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (issue_valid) begin
                    state_next = (issue_mask == '0) ? WRITEBACK : COLLECT;
                end
            end
            COLLECT: begin
                if ((pending & ~accept) == '0) begin
                    state_next = WRITEBACK;
                end
            end
            WRITEBACK: begin
                if (wb_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue_ready = 1'b0;
        wb_valid    = 1'b0;
        case (state)
            IDLE:      issue_ready = 1'b1;
            WRITEBACK: wb_valid    = 1'b1;
            default: begin
                issue_ready = 1'b0;
                wb_valid    = 1'b0;
            end
        endcase
    end

    // Buffer words of non-participating threads are zeroed at issue so wb_data is clean.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending     <= '0;
            data_buf    <= '0;
            wb_mask     <= '0;
            wb_rd       <= '0;
            outstanding <= '0;
            stray_resp  <= 1'b0;
        end else begin
            if (stray_now) begin
                stray_resp <= 1'b1;
            end
            if (do_issue) begin
                pending     <= issue_mask;
                wb_mask     <= issue_mask;
                wb_rd       <= issue_rd;
                outstanding <= issue_count;
                for (int i = 0; i < THREADS_PER_WARP; i++) begin
                    if (!issue_mask[i]) begin
                        data_buf[i] <= '0;
                    end
                end
            end else if (state == COLLECT) begin
                pending     <= pending & ~accept;
                outstanding <= outstanding - accept_count;
                for (int i = 0; i < THREADS_PER_WARP; i++) begin
                    if (accept[i]) begin
                        data_buf[i] <= resp_data[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_wb_collector.sv
// Directed self-checking bench for lsu_wb_collector: one task per scenario,
// inputs driven 1ns after the rising edge and outputs sampled at the same point.
module tb_lsu_wb_collector;

    localparam int T  = 16;
    localparam int DW = 32;
    localparam int CW = 5;

    logic                 clk;
    logic                 reset;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [T-1:0]         issue_mask;
    logic [4:0]           issue_rd;
    logic [T-1:0]         resp_valid;
    logic [T-1:0][DW-1:0] resp_data;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [T-1:0]         wb_mask;
    logic [4:0]           wb_rd;
    logic [T-1:0][DW-1:0] wb_data;
    logic [CW-1:0]        outstanding;
    logic                 stray_resp;

    int checks_total;
    int checks_passed;

    lsu_wb_collector #(
        .THREADS_PER_WARP(T),
        .DATA_WIDTH(DW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_mask(issue_mask),
        .issue_rd(issue_rd),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_mask(wb_mask),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .outstanding(outstanding),
        .stray_resp(stray_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks_total++; if (wb_valid !== 1'b0) $display("[TB] FAIL rst_wb_valid: got %b want 0", wb_valid); else checks_passed++;
        checks_total++; if (outstanding !== 5'd0) $display("[TB] FAIL rst_outstanding: got %0d want 0", outstanding); else checks_passed++;
        checks_total++; if (wb_mask !== 16'h0) $display("[TB] FAIL rst_wb_mask: got %h want 0000", wb_mask); else checks_passed++;
        checks_total++; if (wb_rd !== 5'd0) $display("[TB] FAIL rst_wb_rd: got %0d want 0", wb_rd); else checks_passed++;
        checks_total++; if (wb_data !== '0) $display("[TB] FAIL rst_wb_data: got %h want 0", wb_data); else checks_passed++;
        checks_total++; if (stray_resp !== 1'b0) $display("[TB] FAIL rst_stray: got %b want 0", stray_resp); else checks_passed++;
        reset = 1'b1;
        step();
        checks_total++; if (issue_ready !== 1'b1) $display("[TB] FAIL rst_issue_ready: got %b want 1", issue_ready); else checks_passed++;
    endtask

    task automatic test_full_reverse();
        issue_valid = 1'b1;
        issue_mask  = 16'hFFFF;
        issue_rd    = 5'd5;
        step();
        issue_valid = 1'b0;
        checks_total++; if (outstanding !== 5'd16) $display("[TB] FAIL full_out_init: got %0d want 16", outstanding); else checks_passed++;
        checks_total++; if (issue_ready !== 1'b0) $display("[TB] FAIL full_issue_ready: got %b want 0", issue_ready); else checks_passed++;
        for (int k = T - 1; k >= 0; k--) begin
            resp_valid    = '0;
            resp_valid[k] = 1'b1;
            resp_data[k]  = 32'(100 + k);
            step();
            if (k == 1) begin
                checks_total++; if (wb_valid !== 1'b0) $display("[TB] FAIL full_wb_early: got %b want 0", wb_valid); else checks_passed++;
                checks_total++; if (outstanding !== 5'd1) $display("[TB] FAIL full_out_one: got %0d want 1", outstanding); else checks_passed++;
            end
        end
        resp_valid = '0;
        checks_total++; if (wb_valid !== 1'b1) $display("[TB] FAIL full_wb_valid: got %b want 1", wb_valid); else checks_passed++;
        checks_total++; if (wb_mask !== 16'hFFFF) $display("[TB] FAIL full_wb_mask: got %h want ffff", wb_mask); else checks_passed++;
        checks_total++; if (wb_rd !== 5'd5) $display("[TB] FAIL full_wb_rd: got %0d want 5", wb_rd); else checks_passed++;
        checks_total++; if (outstanding !== 5'd0) $display("[TB] FAIL full_out_zero: got %0d want 0", outstanding); else checks_passed++;
        for (int i = 0; i < T; i++) begin
            checks_total++; if (wb_data[i] !== 32'(100 + i)) $display("[TB] FAIL full_wb_data[%0d]: got %0d want %0d", i, wb_data[i], 100 + i); else checks_passed++;
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checks_total++; if (wb_valid !== 1'b0) $display("[TB] FAIL full_wb_drop: got %b want 0", wb_valid); else checks_passed++;
        checks_total++; if (issue_ready !== 1'b1) $display("[TB] FAIL full_back_idle: got %b want 1", issue_ready); else checks_passed++;
    endtask

    task automatic test_multi_resp();
        logic [T-1:0] mask;
        mask        = 16'h00A5;
        issue_valid = 1'b1;
        issue_mask  = mask;
        issue_rd    = 5'd7;
        step();
        issue_valid = 1'b0;
        checks_total++; if (outstanding !== 5'd4) $display("[TB] FAIL multi_out_init: got %0d want 4", outstanding); else checks_passed++;
        for (int i = 0; i < T; i++) resp_data[i] = 32'h1000 + 32'(i);
        resp_valid = mask;
        step();
        resp_valid = '0;
        checks_total++; if (outstanding !== 5'd0) $display("[TB] FAIL multi_out_zero: got %0d want 0", outstanding); else checks_passed++;
        checks_total++; if (wb_valid !== 1'b1) $display("[TB] FAIL multi_wb_valid: got %b want 1", wb_valid); else checks_passed++;
        checks_total++; if (wb_mask !== mask) $display("[TB] FAIL multi_wb_mask: got %h want %h", wb_mask, mask); else checks_passed++;
        for (int i = 0; i < T; i++) begin
            logic [DW-1:0] exp;
            exp = mask[i] ? (32'h1000 + 32'(i)) : 32'h0;
            checks_total++; if (wb_data[i] !== exp) $display("[TB] FAIL multi_wb_data[%0d]: got %h want %h", i, wb_data[i], exp); else checks_passed++;
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    task automatic test_empty_mask();
        issue_valid = 1'b1;
        issue_mask  = 16'h0000;
        issue_rd    = 5'd9;
        step();
        issue_valid = 1'b0;
        checks_total++; if (wb_valid !== 1'b1) $display("[TB] FAIL empty_wb_valid: got %b want 1", wb_valid); else checks_passed++;
        checks_total++; if (wb_mask !== 16'h0) $display("[TB] FAIL empty_wb_mask: got %h want 0000", wb_mask); else checks_passed++;
        for (int c = 0; c < 5; c++) begin
            step();
            checks_total++; if (wb_valid !== 1'b1) $display("[TB] FAIL empty_hold_valid c%0d: got %b want 1", c, wb_valid); else checks_passed++;
            checks_total++; if (issue_ready !== 1'b0) $display("[TB] FAIL empty_hold_ready c%0d: got %b want 0", c, issue_ready); else checks_passed++;
            checks_total++; if (wb_rd !== 5'd9) $display("[TB] FAIL empty_hold_rd c%0d: got %0d want 9", c, wb_rd); else checks_passed++;
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checks_total++; if (issue_ready !== 1'b1) $display("[TB] FAIL empty_back_idle: got %b want 1", issue_ready); else checks_passed++;
    endtask

    task automatic test_stray();
        checks_total++; if (stray_resp !== 1'b0) $display("[TB] FAIL stray_clean: got %b want 0", stray_resp); else checks_passed++;
        issue_valid = 1'b1;
        issue_mask  = 16'h0003;
        issue_rd    = 5'd3;
        step();
        issue_valid   = 1'b0;
        resp_valid    = 16'h0004;
        resp_data[2]  = 32'hDEAD;
        step();
        checks_total++; if (stray_resp !== 1'b1) $display("[TB] FAIL stray_set: got %b want 1", stray_resp); else checks_passed++;
        checks_total++; if (outstanding !== 5'd2) $display("[TB] FAIL stray_out2: got %0d want 2", outstanding); else checks_passed++;
        resp_valid   = 16'h0001;
        resp_data[0] = 32'h11;
        step();
        resp_data[0] = 32'h99;
        step();
        checks_total++; if (outstanding !== 5'd1) $display("[TB] FAIL stray_dup_out: got %0d want 1", outstanding); else checks_passed++;
        checks_total++; if (wb_valid !== 1'b0) $display("[TB] FAIL stray_dup_wb: got %b want 0", wb_valid); else checks_passed++;
        resp_valid   = 16'h0002;
        resp_data[1] = 32'h22;
        step();
        resp_valid = '0;
        checks_total++; if (wb_valid !== 1'b1) $display("[TB] FAIL stray_wb_valid: got %b want 1", wb_valid); else checks_passed++;
        checks_total++; if (wb_data[0] !== 32'h11) $display("[TB] FAIL stray_data0: got %h want 11", wb_data[0]); else checks_passed++;
        checks_total++; if (wb_data[1] !== 32'h22) $display("[TB] FAIL stray_data1: got %h want 22", wb_data[1]); else checks_passed++;
        checks_total++; if (wb_data[2] !== 32'h0) $display("[TB] FAIL stray_data2: got %h want 0", wb_data[2]); else checks_passed++;
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1;
        issue_mask  = 16'h000F;
        issue_rd    = 5'd4;
        step();
        issue_valid  = 1'b0;
        resp_valid   = 16'h0001;
        resp_data[0] = 32'h77;
        step();
        resp_valid = '0;
        checks_total++; if (outstanding !== 5'd3) $display("[TB] FAIL mid_out3: got %0d want 3", outstanding); else checks_passed++;
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks_total++; if (wb_valid !== 1'b0) $display("[TB] FAIL mid_wb_valid: got %b want 0", wb_valid); else checks_passed++;
        checks_total++; if (outstanding !== 5'd0) $display("[TB] FAIL mid_out0: got %0d want 0", outstanding); else checks_passed++;
        checks_total++; if (issue_ready !== 1'b1) $display("[TB] FAIL mid_idle: got %b want 1", issue_ready); else checks_passed++;
        checks_total++; if (stray_resp !== 1'b0) $display("[TB] FAIL mid_stray_clr: got %b want 0", stray_resp); else checks_passed++;
        resp_valid   = 16'h0002;
        resp_data[1] = 32'h88;
        step();
        resp_valid = '0;
        checks_total++; if (stray_resp !== 1'b1) $display("[TB] FAIL mid_late_stray: got %b want 1", stray_resp); else checks_passed++;
        checks_total++; if (wb_valid !== 1'b0) $display("[TB] FAIL mid_no_wb: got %b want 0", wb_valid); else checks_passed++;
    endtask

    task automatic test_back_to_back();
        issue_valid = 1'b1;
        issue_mask  = 16'h0001;
        issue_rd    = 5'd6;
        step();
        issue_valid  = 1'b0;
        resp_valid   = 16'h0001;
        resp_data[0] = 32'h55;
        step();
        resp_valid = '0;
        checks_total++; if (wb_valid !== 1'b1) $display("[TB] FAIL b2b_wb_valid: got %b want 1", wb_valid); else checks_passed++;
        wb_ready    = 1'b1;
        issue_valid = 1'b1;
        issue_mask  = 16'h0002;
        issue_rd    = 5'd8;
        step();
        wb_ready = 1'b0;
        checks_total++; if (issue_ready !== 1'b1) $display("[TB] FAIL b2b_not_taken: got %b want 1", issue_ready); else checks_passed++;
        checks_total++; if (wb_rd !== 5'd6) $display("[TB] FAIL b2b_rd_kept: got %0d want 6", wb_rd); else checks_passed++;
        checks_total++; if (outstanding !== 5'd0) $display("[TB] FAIL b2b_out0: got %0d want 0", outstanding); else checks_passed++;
        step();
        issue_valid = 1'b0;
        checks_total++; if (issue_ready !== 1'b0) $display("[TB] FAIL b2b_taken: got %b want 0", issue_ready); else checks_passed++;
        checks_total++; if (wb_rd !== 5'd8) $display("[TB] FAIL b2b_rd_new: got %0d want 8", wb_rd); else checks_passed++;
        checks_total++; if (outstanding !== 5'd1) $display("[TB] FAIL b2b_out1: got %0d want 1", outstanding); else checks_passed++;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_mask  = '0;
        issue_rd    = '0;
        resp_valid  = '0;
        resp_data   = '0;
        wb_ready    = 1'b0;
        test_reset();
        test_full_reverse();
        test_multi_resp();
        test_empty_mask();
        test_stray();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
